mutex_system_n: RTL and testbench

Parametrised N-client mutual-exclusion protocol engine: the Murphi-derived rule-scheduled system generalised from a fixed three-client, single-holder lock to NUM_CLIENTS clients sharing a k-holder semaphore. A per-cycle rule-enable vector from the environment or formal harness selects one guarded transition per cycle. New over the previous generation:
- invariant checker with sticky violation flag;
- per-client starvation counters;
- fired/rule-index observability for equivalence and trace checking.

---
 rtl/mutex_system_n.sv | 171 +++++++++++++++++
 tb/tb_mutex_system_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mutex_system_n.sv
// mutex_system_n: N-client k-holder semaphore protocol engine.
// One guarded transition per cycle, picked as the lowest set bit of the
// rule-enable vector. Also tracks per-client starvation and latches any
// broken occupancy invariant.
module mutex_system_n #(
  parameter int NUM_CLIENTS = 3,
  parameter int MAX_CRIT    = 1,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [4*NUM_CLIENTS-1:0]            io_en_a,
  output logic [2*NUM_CLIENTS-1:0]            io_state,
  output logic [$clog2(MAX_CRIT+1)-1:0]       io_holders,
  output logic                                io_fired,
  output logic [$clog2(4*NUM_CLIENTS)-1:0]    io_rule_idx,
  output logic [NUM_CLIENTS-1:0]              io_starved,
  output logic                                io_violation
);

  localparam int HW = $clog2(MAX_CRIT + 1);
  localparam int IW = $clog2(4 * NUM_CLIENTS);
  localparam int WW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_T = 2'd1,
    ST_C = 2'd2,
    ST_E = 2'd3
  } client_st_e;

  logic [2*NUM_CLIENTS-1:0] r_state;
  logic [HW-1:0]            r_holders;
  logic                     r_fired;
  logic [IW-1:0]            r_rule_idx;
  logic [WW-1:0]            r_wait [NUM_CLIENTS];
  logic                     r_violation;

  logic                     w_sel_valid;
  logic [IW-1:0]            w_sel_idx;
  int                       w_client;
  logic [1:0]               w_rule;
  logic [1:0]               w_cur;
  logic [2*NUM_CLIENTS-1:0] w_state_nxt;
  logic [HW-1:0]            w_holders_nxt;
  logic                     w_fired_nxt;
  logic [IW-1:0]            w_idx_nxt;
  logic [WW-1:0]            w_wait_nxt [NUM_CLIENTS];
  int                       w_ce_count;
  logic                     w_inv_fail;

  // Pick the lowest-index enabled rule; scanning downward lets the last hit win.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int k = 4*NUM_CLIENTS-1; k >= 0; k--) begin
      if (io_en_a[k]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IW'(k);
      end
    end
  end

  // Apply the selected rule if its guard holds; a false guard is a stutter
  // that still records which rule was attempted.
  always_comb begin
    w_state_nxt   = r_state;
    w_holders_nxt = r_holders;
    w_fired_nxt   = 1'b0;
    w_idx_nxt     = r_rule_idx;
    w_client      = int'(w_sel_idx >> 2);
    w_rule        = w_sel_idx[1:0];
    w_cur         = r_state[2*w_client +: 2];
    if (w_sel_valid) begin
      w_idx_nxt = w_sel_idx;
      case (w_rule)
        2'd0: begin
          if (w_cur == ST_I) begin
            w_state_nxt[2*w_client +: 2] = ST_T;
            w_fired_nxt                  = 1'b1;
          end
        end
        2'd1: begin
          if ((w_cur == ST_T) && (int'(r_holders) < MAX_CRIT)) begin
            w_state_nxt[2*w_client +: 2] = ST_C;
            w_holders_nxt                = r_holders + HW'(1);
            w_fired_nxt                  = 1'b1;
          end
        end
        2'd2: begin
          if (w_cur == ST_C) begin
            w_state_nxt[2*w_client +: 2] = ST_E;
            w_fired_nxt                  = 1'b1;
          end
        end
        default: begin
          if (w_cur == ST_E) begin
            w_state_nxt[2*w_client +: 2] = ST_I;
            w_holders_nxt                = r_holders - HW'(1);
            w_fired_nxt                  = 1'b1;
          end
        end
      endcase
    end
  end

  // Wait counters run while a client sits in T, saturate at the limit, and
  // clear both when the client leaves T and whenever it is elsewhere.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_wait_nxt[i] = '0;
      if ((r_state[2*i +: 2] == ST_T) && (w_state_nxt[2*i +: 2] == ST_T)) begin
        if (r_wait[i] != WW'(WAIT_LIMIT)) begin
          w_wait_nxt[i] = r_wait[i] + WW'(1);
        end else begin
          w_wait_nxt[i] = r_wait[i];
        end
      end
    end
  end

  // Occupancy invariant on the current registers: the holder count must match
  // the clients in C or E and must never exceed the allowed number of holders.
  always_comb begin
    w_ce_count = 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (r_state[2*i+1]) begin
        w_ce_count = w_ce_count + 1;
      end
    end
    w_inv_fail = (w_ce_count != int'(r_holders)) || (int'(r_holders) > MAX_CRIT);
  end

  // State register; reset wins over any rule on the same edge, and the
  // violation flag is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= '0;
      r_holders   <= '0;
      r_fired     <= 1'b0;
      r_rule_idx  <= '0;
      r_violation <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_wait[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_holders   <= w_holders_nxt;
      r_fired     <= w_fired_nxt;
      r_rule_idx  <= w_idx_nxt;
      r_violation <= r_violation | w_inv_fail;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_wait[i] <= w_wait_nxt[i];
      end
    end
  end

  // Starvation flags decode only registered counters, so no enable reaches outputs.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      io_starved[i] = (r_wait[i] == WW'(WAIT_LIMIT));
    end
  end

  assign io_state     = r_state;
  assign io_holders   = r_holders;
  assign io_fired     = r_fired;
  assign io_rule_idx  = r_rule_idx;
  assign io_violation = r_violation;

endmodule

// File: tb/tb_mutex_system_n.sv
// Directed bench for mutex_system_n: a classic 3-client mutex instance and a
// 4-client 2-holder instance, with expected outputs queued at each drive and
// popped after the following clock edge.
module tb_mutex_system_n;

  logic        clock = 1'b0;
  logic        rstA  = 1'b1;
  logic        rstB  = 1'b1;
  logic [11:0] enA   = '0;
  logic [15:0] enB   = '0;

  logic [5:0]  stA;
  logic        holdA;
  logic        firedA;
  logic [3:0]  idxA;
  logic [2:0]  svA;
  logic        violA;

  logic [7:0]  stB;
  logic [1:0]  holdB;
  logic        firedB;
  logic [3:0]  idxB;
  logic [3:0]  svB;
  logic        violB;

  typedef struct {
    logic       which;
    logic [7:0] st;
    logic [1:0] h;
    logic       f;
    logic [3:0] idx;
    logic [3:0] sv;
    logic       v;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];
  int    testCount = 0;
  int    failCount = 0;

  mutex_system_n #(.NUM_CLIENTS(3), .MAX_CRIT(1), .WAIT_LIMIT(15)) dut (
    .clock       (clock),
    .reset       (rstA),
    .io_en_a     (enA),
    .io_state    (stA),
    .io_holders  (holdA),
    .io_fired    (firedA),
    .io_rule_idx (idxA),
    .io_starved  (svA),
    .io_violation(violA)
  );

  mutex_system_n #(.NUM_CLIENTS(4), .MAX_CRIT(2), .WAIT_LIMIT(15)) dut4 (
    .clock       (clock),
    .reset       (rstB),
    .io_en_a     (enB),
    .io_state    (stB),
    .io_holders  (holdB),
    .io_fired    (firedB),
    .io_rule_idx (idxB),
    .io_starved  (svB),
    .io_violation(violB)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] bitN(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  task automatic checkField(input string tag, input string field,
                            input logic [7:0] obs, input logic [7:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string tag;
    if (expQ.size() == 0) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL scoreboard empty observed=0 expected=1");
      return;
    end
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    if (e.which == 1'b0) begin
      checkField(tag, "state",   8'(stA),   e.st);
      checkField(tag, "holders", 8'(holdA), 8'(e.h));
      checkField(tag, "fired",   8'(firedA), 8'(e.f));
      checkField(tag, "ruleIdx", 8'(idxA),  8'(e.idx));
      checkField(tag, "starved", 8'(svA),   8'(e.sv));
      checkField(tag, "viol",    8'(violA), 8'(e.v));
    end else begin
      checkField(tag, "state",   8'(stB),   e.st);
      checkField(tag, "holders", 8'(holdB), 8'(e.h));
      checkField(tag, "fired",   8'(firedB), 8'(e.f));
      checkField(tag, "ruleIdx", 8'(idxB),  8'(e.idx));
      checkField(tag, "starved", 8'(svB),   8'(e.sv));
      checkField(tag, "viol",    8'(violB), 8'(e.v));
    end
  endtask

  task automatic applyStimulus(input logic which, input logic rst, input logic [15:0] en,
                               input string tag, input logic [7:0] st, input logic [1:0] h,
                               input logic f, input logic [3:0] idx, input logic [3:0] sv,
                               input logic v);
    exp_t e;
    @(negedge clock);
    if (which == 1'b0) begin
      rstA = rst;
      enA  = en[11:0];
    end else begin
      rstB = rst;
      enB  = en;
    end
    e.which = which;
    e.st    = st;
    e.h     = h;
    e.f     = f;
    e.idx   = idx;
    e.sv    = sv;
    e.v     = v;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    // Classic mutex instance: reset, idle cycles, single-client walk.
    applyStimulus(0, 1, 16'h0001, "resetA",  8'h00, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, "idle0",   8'h00, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, "idle1",   8'h00, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, bitN(0),  "try0",    8'h01, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, bitN(1),  "crit0",   8'h02, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, bitN(2),  "exit0",   8'h03, 1, 1, 2, 0, 0);
    applyStimulus(0, 0, bitN(3),  "idle0r",  8'h00, 0, 1, 3, 0, 0);

    // Priority, then contention and starvation of client 1.
    applyStimulus(0, 0, 16'h0021, "prio",    8'h01, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, bitN(4),  "try1",    8'h05, 0, 1, 4, 0, 0);
    applyStimulus(0, 0, bitN(1),  "crit0b",  8'h06, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, bitN(5),  "crit1St", 8'h06, 1, 0, 5, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(0, 0, 16'h0000, "starveWait", 8'h06, 1, 0, 5,
                    (k == 13) ? 4'h2 : 4'h0, 0);
    end
    applyStimulus(0, 0, 16'h0000, "starveSat", 8'h06, 1, 0, 5, 4'h2, 0);
    applyStimulus(0, 0, bitN(2),  "exit0b",  8'h07, 1, 1, 2, 4'h2, 0);
    applyStimulus(0, 0, bitN(3),  "idle0b",  8'h04, 0, 1, 3, 4'h2, 0);
    applyStimulus(0, 0, bitN(5),  "crit1",   8'h08, 1, 1, 5, 4'h0, 0);
    applyStimulus(0, 0, bitN(6),  "exit1",   8'h0C, 1, 1, 6, 0, 0);
    applyStimulus(0, 0, bitN(7),  "idle1r",  8'h00, 0, 1, 7, 0, 0);

    // Reset mid-operation overrides the enabled rule.
    applyStimulus(0, 0, bitN(8),  "try2",    8'h10, 0, 1, 8, 0, 0);
    applyStimulus(0, 1, bitN(9),  "midRst",  8'h00, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0000, "postRst", 8'h00, 0, 0, 0, 0, 0);

    // Invariant: two clients in C with a holder count of one.
    dut.r_state   = 6'b001010;
    dut.r_holders = 1'b1;
    applyStimulus(0, 0, 16'h0000, "viol1",   8'h0A, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 16'h0000, "violSt",  8'h0A, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 16'h0000, "violRst", 8'h00, 0, 0, 0, 0, 0);

    // k-exclusion instance: two holders allowed, third must wait.
    applyStimulus(1, 1, 16'h0001, "resetB",  8'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, bitN(0),  "kTry0",   8'h01, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, bitN(4),  "kTry1",   8'h05, 0, 1, 4, 0, 0);
    applyStimulus(1, 0, bitN(8),  "kTry2",   8'h15, 0, 1, 8, 0, 0);
    applyStimulus(1, 0, bitN(1),  "kCrit0",  8'h16, 1, 1, 1, 0, 0);
    applyStimulus(1, 0, bitN(5),  "kCrit1",  8'h1A, 2, 1, 5, 0, 0);
    applyStimulus(1, 0, bitN(9),  "kCrit2St",8'h1A, 2, 0, 9, 0, 0);
    applyStimulus(1, 0, bitN(2),  "kExit0",  8'h1B, 2, 1, 2, 0, 0);
    applyStimulus(1, 0, bitN(3),  "kIdle0",  8'h18, 1, 1, 3, 0, 0);
    applyStimulus(1, 0, bitN(9),  "kCrit2",  8'h28, 2, 1, 9, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
